// File: rtl/ddr_burst_writer.sv
// Buffers an upstream word stream and drains it to memory as fixed-length AXI INCR
// write bursts, walking a frame of FRAME_BURSTS bursts that wraps back to BASE.
module ddr_burst_writer #(
  parameter int              W            = 64,
  parameter int              BURST        = 16,
  parameter int              AW           = 32,
  parameter logic [AW-1:0]   BASE         = '0,
  parameter int              FRAME_BURSTS = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              srst_i,
  input  logic              in_val_i,
  input  logic [W-1:0]      in_data_i,
  output logic              in_rdy_o,
  output logic [AW-1:0]     m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [W-1:0]      m_wdata,
  output logic [W/8-1:0]    m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              err_o,
  output logic              frame_done_o,
  output logic [1:0]        dbg_state_o
);

  localparam int DEPTH = 2 * BURST;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int IW    = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int SIZE  = $clog2(W / 8);
  localparam logic [AW-1:0] BURST_BYTES = AW'(BURST * W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            flush_pending_q, flush_pending_d;
  logic            err_q, err_d;
  logic            frame_done_q, frame_done_d;
  logic [W-1:0]    mem_q [DEPTH];

  logic push, pop, last_beat, flush_req, flush_apply;

  // Every channel uses AXI valid/ready: a transfer happens on a rising edge where both
  // are high; a source never drops valid or changes payload while waiting for ready.

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_rdy_o  = (count_q < CW'(DEPTH)) && !flush_pending_q;
  assign push      = in_val_i && in_rdy_o;
  assign pop       = (state_q == DATA) && m_wready;
  assign last_beat = (beat_q == BW'(BURST - 1));

  // A restart outside IDLE is deferred so the burst in flight stays AXI-legal; it then
  // lands on the same edge as the B handshake that returns the FSM to IDLE.
  assign flush_req   = srst_i && (state_q != IDLE) && !flush_pending_q;
  assign flush_apply = (srst_i && state_q == IDLE) ||
                       ((state_q == RESP) && m_bvalid && (flush_pending_q || flush_req));

  always_comb begin
    state_d         = state_q;
    count_d         = count_q + CW'(push) - CW'(pop);
    wr_ptr_d        = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d        = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    addr_d          = addr_q;
    idx_d           = idx_q;
    beat_d          = beat_q;
    flush_pending_d = flush_pending_q;
    err_d           = err_q;
    frame_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q >= CW'(BURST) && !flush_pending_q && !srst_i) state_d = ADDR;
      end
      ADDR: begin
        if (m_awready) state_d = DATA;
      end
      DATA: begin
        if (m_wready) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      RESP: begin
        if (m_bvalid) begin
          state_d = IDLE;
          if (m_bresp != 2'b00) err_d = 1'b1;
          if (idx_q == IW'(FRAME_BURSTS - 1)) begin
            addr_d       = BASE;
            idx_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            addr_d = addr_q + BURST_BYTES;
            idx_d  = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_req) flush_pending_d = 1'b1;

    if (flush_apply) begin
      count_d         = '0;
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      addr_d          = BASE;
      idx_d           = '0;
      err_d           = 1'b0;
      flush_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      addr_q          <= BASE;
      idx_q           <= '0;
      beat_q          <= '0;
      flush_pending_q <= 1'b0;
      err_q           <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      addr_q          <= addr_d;
      idx_q           <= idx_d;
      beat_q          <= beat_d;
      flush_pending_q <= flush_pending_d;
      err_q           <= err_d;
      frame_done_q    <= frame_done_d;
    end
  end

  // Storage needs no reset: pointers and count decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  assign m_awaddr     = addr_q;
  assign m_awlen      = 8'(BURST - 1);
  assign m_awsize     = 3'(SIZE);
  assign m_awburst    = 2'b01;
  assign m_awvalid    = (state_q == ADDR);
  assign m_wdata      = mem_q[rd_ptr_q];
  assign m_wstrb      = '1;
  assign m_wvalid     = (state_q == DATA);
  assign m_wlast      = (state_q == DATA) && last_beat;
  assign m_bready     = (state_q == RESP);
  assign err_o        = err_q;
  assign frame_done_o = frame_done_q;
  assign dbg_state_o  = state_q;

endmodule
